// File: rtl/fifo16_wr_arbiter.sv
// Round-robin, credit-flow-controlled arbiter feeding the 1-bit write port of a 16-entry serial FIFO.
// Optional accepted-bit counter is compiled in with FIFO16_ARB_STATS_EN.
module fifo16_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 8,
    parameter int DEPTH     = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] req_din_i,
    input  logic [N_REQ-1:0] req_dv_i,
    input  logic [N_REQ-1:0] req_last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             ready_o,
    output logic             fifo_din_o,
    output logic             fifo_din_dv_o,
    input  logic             credit_ret_i,
    output logic [4:0]       credits_o,
    output logic             credit_err_o,
    output logic             busy_o,
    output logic [15:0]      stat_bits_o
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [3:0]       burst_q, burst_d;
    logic [4:0]       credits_q, credits_d;
    logic             err_q, err_d;
    logic             din_q, din_d;
    logic             dv_q, dv_d;

    logic             ready, accept, sel_last, sel_din, sel_req, found;
    logic [PTR_W-1:0] sel_idx;
    int               rr_idx;

    assign ready    = (state_q == ST_XFER) && (credits_q != 5'd0);
    assign accept   = ready && |(gnt_q & req_dv_i);
    assign sel_last = |(gnt_q & req_last_i);
    assign sel_din  = |(gnt_q & req_din_i);
    assign sel_req  = |(gnt_q & req_i);

    // Search starts one past the last granted requester so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        sel_idx = ptr_q;
        rr_idx  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
            if (!found && req_i[PTR_W'(rr_idx)]) begin
                found   = 1'b1;
                sel_idx = PTR_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        din_d   = din_q;
        dv_d    = accept;
        if (accept) din_d = sel_din;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_XFER;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    ptr_d   = sel_idx;
                    burst_d = 4'd0;
                end
            end
            default: begin
                if (accept) burst_d = burst_q + 4'd1;
                // The IDLE hop after every burst produces the mandatory one-cycle grant gap.
                if ((accept && (sel_last || burst_q == 4'(BURST_MAX - 1))) || !sel_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (accept && !credit_ret_i) begin
            credits_d = credits_q - 5'd1;
        end else if (credit_ret_i && !accept) begin
            if (credits_q == 5'(DEPTH)) err_d = 1'b1;
            else                        credits_d = credits_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= PTR_W'(N_REQ - 1);
            burst_q   <= 4'd0;
            credits_q <= 5'(DEPTH);
            err_q     <= 1'b0;
            din_q     <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            din_q     <= din_d;
            dv_q      <= dv_d;
        end
    end

`ifdef FIFO16_ARB_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)       stat_q <= 16'h0000;
        else if (accept) stat_q <= stat_q + 16'd1;
    end
    assign stat_bits_o = stat_q;
`else
    assign stat_bits_o = 16'h0000;
`endif

    assign gnt_o         = gnt_q;
    assign ready_o       = ready;
    assign fifo_din_o    = din_q;
    assign fifo_din_dv_o = dv_q;
    assign credits_o     = credits_q;
    assign credit_err_o  = err_q;
    assign busy_o        = (state_q == ST_XFER);
endmodule

// File: tb/tb_fifo16_wr_arbiter.sv
// Bench for fifo16_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo16_wr_arbiter;
    localparam int N  = 4;
    localparam int BM = 8;
    localparam int D  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i = 1'b1;
    logic [N-1:0] req_i = '0, req_din_i = '0, req_dv_i = '0, req_last_i = '0;
    logic         credit_ret_i = 1'b0;
    logic [N-1:0] gnt_o;
    logic         ready_o, fifo_din_o, fifo_din_dv_o, credit_err_o, busy_o;
    logic [4:0]   credits_o;
    logic [15:0]  stat_bits_o;

    fifo16_wr_arbiter #(.N_REQ(N), .BURST_MAX(BM), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_din_i(req_din_i),
        .req_dv_i(req_dv_i), .req_last_i(req_last_i), .gnt_o(gnt_o), .ready_o(ready_o),
        .fifo_din_o(fifo_din_o), .fifo_din_dv_o(fifo_din_dv_o), .credit_ret_i(credit_ret_i),
        .credits_o(credits_o), .credit_err_o(credit_err_o), .busy_o(busy_o),
        .stat_bits_o(stat_bits_o)
    );

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: owner is -1 when nobody holds the port.
    int       m_owner = -1, m_ptr = N - 1, m_bits = 0, m_credits = D, m_stat = 0;
    bit       m_err = 0, m_dv = 0, m_din = 0, m_a = 0;
    bit [N-1:0] m_acc = '0;
    bit       chk_en = 0;
    logic [N-1:0] run_g[$];
    int           run_n[$];
    logic [N-1:0] cur_g = '0;
    int           cur_n = 0;
    int           dv_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", gnt_o, (m_owner < 0) ? 0 : (1 << m_owner));
            chk("ready", ready_o, (m_owner >= 0 && m_credits != 0) ? 1 : 0);
            chk("busy", busy_o, (m_owner >= 0) ? 1 : 0);
            chk("din_dv", fifo_din_dv_o, m_dv);
            if (m_dv) chk("din", fifo_din_o, m_din);
            chk("credits", credits_o, m_credits);
            chk("credit_err", credit_err_o, m_err);
`ifdef FIFO16_ARB_STATS_EN
            chk("stat", stat_bits_o, m_stat);
`else
            chk("stat", stat_bits_o, 0);
`endif
            if (gnt_o == cur_g) cur_n++;
            else begin
                run_g.push_back(cur_g); run_n.push_back(cur_n);
                cur_g = gnt_o; cur_n = 1;
            end
            if (fifo_din_dv_o) dv_cnt++;
        end
        if (rst_i) begin
            m_owner = -1; m_ptr = N - 1; m_bits = 0; m_credits = D; m_stat = 0;
            m_err = 0; m_dv = 0; m_din = 0; m_acc = '0;
        end else begin
            m_a = (m_owner >= 0) && req_dv_i[m_owner] && (m_credits > 0);
            m_acc = '0;
            if (m_a) begin
                m_acc[m_owner] = 1'b1;
                m_din = req_din_i[m_owner];
                m_stat = (m_stat + 1) % 65536;
            end
            m_dv = m_a;
            if (m_a && !credit_ret_i) m_credits--;
            else if (credit_ret_i && !m_a) begin
                if (m_credits == D) m_err = 1;
                else m_credits++;
            end
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++)
                    if (req_i[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N; m_ptr = m_owner; m_bits = 0; break;
                    end
            end else begin
                if (m_a) m_bits++;
                if ((m_a && req_last_i[m_owner]) || m_bits == BM || !req_i[m_owner]) m_owner = -1;
            end
        end
    end

    // Requester agents: each holds a bit string and advances only when its bit was taken.
    logic [63:0] a_data[N];
    int          a_rem[N];
    int          a_pos[N];
    bit          a_last[N];
    bit          dv_rand = 0;
    int          ret_mode = 0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (m_acc[i] && a_rem[i] > 0) begin a_pos[i]++; a_rem[i]--; end
            req_i[i]      = (a_rem[i] > 0);
            req_din_i[i]  = (a_rem[i] > 0) ? a_data[i][a_pos[i]] : 1'($urandom);
            req_dv_i[i]   = (a_rem[i] > 0) && (!dv_rand || $urandom_range(0, 3) != 0);
            req_last_i[i] = req_dv_i[i] && a_last[i] && a_rem[i] == 1;
        end
        case (ret_mode)
            1: credit_ret_i = (m_credits < D);
            2: credit_ret_i = (m_credits < D) && ($urandom_range(0, 2) == 0);
            3: begin credit_ret_i = 1'b1; ret_mode = 0; end
            default: credit_ret_i = 1'b0;
        endcase
    endtask

    task automatic step(); @(posedge clk); #1; drive(); endtask
    task automatic stepn(input int n); for (int i = 0; i < n; i++) step(); endtask

    task automatic load(input int i, input int n, input bit last);
        a_data[i] = {$urandom, $urandom}; a_rem[i] = n; a_pos[i] = 0; a_last[i] = last;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin a_rem[i] = 0; a_pos[i] = 0; a_last[i] = 0; end
        ret_mode = 0; dv_rand = 0;
        rst_i = 1'b1; step(); step(); rst_i = 1'b0;
    endtask

    function automatic bit all_done();
        bit r = (m_owner < 0) && (m_credits == D);
        for (int i = 0; i < N; i++) if (a_rem[i] != 0) r = 0;
        return r;
    endfunction

    task automatic wait_idle(input string name, input int maxc);
        int c = 0;
        while (c < maxc && !all_done()) begin step(); c++; end
        chk({name, "_timeout"}, (c < maxc) ? 1 : 0, 1);
        stepn(3);
    endtask

    logic [N-1:0] exp_g[$];
    int           exp_n[$];
    task automatic check_runs(input string name, input int from);
        int k = from;
        while (k < run_g.size() && run_g[k] == '0) k++;
        chk({name, "_runs"}, (run_g.size() - k >= exp_g.size()) ? 1 : 0, 1);
        if (run_g.size() - k >= exp_g.size())
            for (int j = 0; j < exp_g.size(); j++) begin
                chk({name, "_gnt"}, run_g[k + j], exp_g[j]);
                chk({name, "_len"}, run_n[k + j], exp_n[j]);
            end
    endtask

    int base, idx0;
    bit hit;
    initial begin
        for (int i = 0; i < N; i++) begin a_rem[i] = 0; a_pos[i] = 0; a_last[i] = 0; a_data[i] = '0; end
        // T1 reset values
        do_reset();
        chk("t1_gnt", gnt_o, 0);
        chk("t1_dv", fifo_din_dv_o, 0);
        chk("t1_busy", busy_o, 0);
        chk("t1_credits", credits_o, 15);
        chk("t1_err", credit_err_o, 0);
        chk_en = 1;

        // T2 credit limit on a single requester
        do_reset(); idx0 = run_g.size(); base = dv_cnt;
        load(2, 20, 0);
        stepn(40);
        chk("t2_bits", dv_cnt - base, 15);
        chk("t2_credits", credits_o, 0);
        chk("t2_ready", ready_o, 0);
        exp_g = '{4'b0100, 4'b0000}; exp_n = '{8, 1};
        check_runs("t2", idx0);
        for (int p = 0; p < 3; p++) begin ret_mode = 3; stepn(3); end
        stepn(20);
        chk("t2_bits_after_ret", dv_cnt - base, 18);
        ret_mode = 1; wait_idle("t2", 200);

        // T3 round-robin with all requesters busy
        do_reset(); idx0 = run_g.size();
        for (int i = 0; i < N; i++) load(i, 20, 0);
        ret_mode = 1;
        stepn(60);
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_n = '{8, 1, 8, 1, 8, 1, 8, 1, 8};
        check_runs("t3", idx0);
        wait_idle("t3", 300);

        // T4 early end via REQ_LAST
        do_reset(); idx0 = run_g.size(); base = dv_cnt;
        load(1, 3, 1); load(2, 5, 0); ret_mode = 1;
        stepn(30);
        exp_g = '{4'b0010, 4'b0000, 4'b0100}; exp_n = '{3, 1, 6};
        check_runs("t4", idx0);
        chk("t4_bits", dv_cnt - base, 8);

        // T5 credit corners
        do_reset(); load(0, 40, 0); hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            step();
            if (m_owner == 0 && m_credits == 5 && req_dv_i[0]) begin
                credit_ret_i = 1'b1; hit = 1; step();
                chk("t5_credits_same", credits_o, 5);
                chk("t5_dv_same", fifo_din_dv_o, 1);
            end
        end
        chk("t5_hit", hit, 1);
        ret_mode = 1; wait_idle("t5", 300);
        chk("t5_err_before", credit_err_o, 0);
        ret_mode = 3; stepn(2);
        chk("t5_credits_full", credits_o, 15);
        chk("t5_err_set", credit_err_o, 1);
        stepn(5);
        chk("t5_err_sticky", credit_err_o, 1);
        do_reset();
        chk("t5_err_cleared", credit_err_o, 0);

        // T6 accepted-bit statistics
        do_reset(); base = dv_cnt;
        load(0, 10, 1); load(1, 12, 0); load(3, 15, 1);
        dv_rand = 1; ret_mode = 1;
        wait_idle("t6", 400);
        chk("t6_bits", dv_cnt - base, 37);
`ifdef FIFO16_ARB_STATS_EN
        chk("t6_stat", stat_bits_o, 37);
`else
        chk("t6_stat", stat_bits_o, 0);
`endif

        // Randomized traffic
        do_reset(); dv_rand = 1; ret_mode = 2;
        for (int c = 0; c < 2500; c++) begin
            step();
            for (int i = 0; i < N; i++)
                if (a_rem[i] == 0 && $urandom_range(0, 19) == 0)
                    load(i, $urandom_range(1, 25), 1'($urandom));
        end
        ret_mode = 1; wait_idle("rand", 3000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
